collatz_inverse_search: RTL and testbench

Inverse companion to the Collatz step counter: the counter maps a seed N to its step count, and this block maps a target step count T back to the smallest seed N in 1..255 with exactly T steps. It sits as a TinyTapeout user tile with the standard pin set. It sweeps candidates in ascending order, iterating the Collatz map at one step per clock, and reports the first match or a not-found result.

---
 rtl/collatz_search_pkg.sv | 19 +
 rtl/collatz_step.sv | 17 +
 rtl/collatz_inverse_search.sv | 103 ++++++++++
 tb/tb_collatz_inverse_search.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/collatz_search_pkg.sv
// Shared types and constants for the Collatz inverse search tile.
package collatz_search_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int VAL_W   = 16;
    localparam int CNT_W   = 8;
    localparam int MAX_N   = 255;

    localparam int BUSY_B  = 1;
    localparam int DONE_B  = 2;
    localparam int FOUND_B = 3;

endpackage

// File: rtl/collatz_step.sv
// One application of the Collatz map: odd -> 3n+1, even -> n/2.
module collatz_step #(
    parameter int VAL_W = 16
) (
    input  logic [VAL_W-1:0] n,
    output logic [VAL_W-1:0] next_n
);

    always_comb begin
        if (n[0]) begin
            next_n = (n << 1) + n + VAL_W'(1);
        end else begin
            next_n = n >> 1;
        end
    end

endmodule

// File: rtl/collatz_inverse_search.sv
// Finds the smallest seed in 1..MAX_N whose Collatz step count equals ui_in.
module collatz_inverse_search
    import collatz_search_pkg::*;
#(
    parameter int MAX_N = 255,
    parameter int VAL_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [7:0] LAST_CAND = 8'(MAX_N);

    state_t             state;
    logic [7:0]         t_reg;
    logic [7:0]         cand;
    logic [VAL_W-1:0]   n;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         res;
    logic               found;
    logic [VAL_W-1:0]   next_n;
    logic               start;
    logic               n_is_one;
    logic               cnt_hit;
    logic               unused;

    assign start    = uio_in[0];
    assign n_is_one = (n == VAL_W'(1));
    assign cnt_hit  = (cnt == t_reg);
    assign unused   = &{1'b0, ena, uio_in[7:1]};

    collatz_step #(.VAL_W(VAL_W)) u_step (
        .n      (n),
        .next_n (next_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            t_reg <= '0;
            cand  <= '0;
            n     <= '0;
            cnt   <= '0;
            res   <= '0;
            found <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        t_reg <= ui_in;
                        cand  <= 8'd1;
                        res   <= '0;
                        found <= 1'b0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    n     <= VAL_W'(cand);
                    cnt   <= '0;
                    state <= ITER;
                end
                ITER: begin
                    if (n_is_one && cnt_hit) begin
                        res   <= cand;
                        found <= 1'b1;
                        state <= DONE;
                    end else if (n_is_one || cnt_hit) begin
                        // Reached 1 too early, or already at T steps without reaching 1.
                        if (cand == LAST_CAND) begin
                            res   <= '0;
                            found <= 1'b0;
                            state <= DONE;
                        end else begin
                            cand  <= cand + 8'd1;
                            state <= LOAD;
                        end
                    end else begin
                        n   <= next_n;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign uo_out = res;
    assign uio_oe = 8'b0000_1110;

    always_comb begin
        uio_out          = '0;
        uio_out[BUSY_B]  = (state == LOAD) || (state == ITER);
        uio_out[DONE_B]  = (state == DONE);
        uio_out[FOUND_B] = found;
    end

endmodule

// File: tb/tb_collatz_inverse_search.sv
// Scoreboard bench for collatz_inverse_search against a software Collatz model.
module tb_collatz_inverse_search;

    typedef struct {
        int t;
        int n;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'd0;
    logic [7:0] uio_in = 8'd0;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    collatz_inverse_search dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    function automatic int ref_steps(input int seed);
        int v = seed;
        int c = 0;
        while (v != 1) begin
            v = (v % 2 == 1) ? 3 * v + 1 : v / 2;
            c++;
        end
        return c;
    endfunction

    function automatic int ref_inverse(input int t);
        for (int s = 1; s <= 255; s++) begin
            if (ref_steps(s) == t) return s;
        end
        return 0;
    endfunction

    // Clock edges from the accepting edge until done: per candidate 1 LOAD + min(steps,T)+1 ITER.
    function automatic int ref_cycles(input int t);
        int total = 0;
        int s;
        for (int c = 1; c <= 255; c++) begin
            s = ref_steps(c);
            total += 2 + ((s < t) ? s : t);
            if (s == t) return total;
        end
        return total;
    endfunction

    task automatic start_search(input logic [7:0] t);
        @(negedge clk);
        ui_in     = t;
        uio_in[0] = 1'b1;
        @(posedge clk);
        #1;
        uio_in[0] = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc, output bit busy_ok, output bit timed_out);
        cyc       = 0;
        busy_ok   = 1'b1;
        timed_out = 1'b0;
        while (uio_out[2] !== 1'b1) begin
            if (cyc >= max_cyc) begin
                timed_out = 1'b1;
                break;
            end
            if (uio_out[1] !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        int  cyc;
        bit  bok, to;
        exp_t e;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo_out got=%h want=00", uo_out); end
        n_tests++;
        if (uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio_out got=%h want=00", uio_out); end
        n_tests++;
        if (uio_oe !== 8'h0E) begin n_fail++; $display("FAIL reset_uio_oe got=%h want=0e", uio_oe); end
        rst_n = 1'b1;

        start_search(8'd127);
        repeat (50) @(posedge clk);
        #1;
        n_tests++;
        if (uio_out[1] !== 1'b1) begin n_fail++; $display("FAIL midsearch_busy got=%b want=1", uio_out[1]); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            n_fail++;
            $display("FAIL midsearch_reset got uo=%h uio=%h want 00/00", uo_out, uio_out);
        end
        @(negedge clk);
        rst_n = 1'b1;

        sb.push_back(exp_t'{7, 3, ref_cycles(7)});
        start_search(8'd7);
        wait_done(70000, cyc, bok, to);
        e = sb.pop_front();
        n_tests++;
        if (to || uo_out !== 8'(e.n)) begin
            n_fail++;
            $display("FAIL post_reset_search t=%0d got=%0d want=%0d timeout=%0b", e.t, uo_out, e.n, to);
        end
    endtask

    task automatic test_t0_latency();
        int cyc;
        bit bok, to;
        exp_t e;
        sb.push_back(exp_t'{0, 1, 2});
        start_search(8'd0);
        wait_done(100, cyc, bok, to);
        e = sb.pop_front();
        n_tests++;
        if (to || cyc + 1 != 3) begin
            n_fail++;
            $display("FAIL t0_latency edges_incl_start got=%0d want=3 timeout=%0b", cyc + 1, to);
        end
        n_tests++;
        if (uo_out !== 8'(e.n) || uio_out[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL t0_result got n=%0d found=%b want n=%0d found=1", uo_out, uio_out[3], e.n);
        end
    endtask

    task automatic test_known();
        int ts[6] = '{1, 2, 5, 7, 111, 127};
        int ns[6] = '{2, 4, 5, 3, 27, 231};
        int cyc;
        bit bok, to;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(exp_t'{ts[i], ns[i], ref_cycles(ts[i])});
            start_search(8'(ts[i]));
            wait_done(70000, cyc, bok, to);
            e = sb.pop_front();
            n_tests++;
            if (to || uo_out !== 8'(e.n) || uio_out[3] !== 1'b1) begin
                n_fail++;
                $display("FAIL known t=%0d got n=%0d found=%b want n=%0d found=1 timeout=%0b",
                         e.t, uo_out, uio_out[3], e.n, to);
            end
            n_tests++;
            if (cyc != e.cyc || !bok) begin
                n_fail++;
                $display("FAIL known_timing t=%0d got cyc=%0d busy_ok=%0b want cyc=%0d busy_ok=1",
                         e.t, cyc, bok, e.cyc);
            end
        end
    endtask

    task automatic test_not_found();
        int cyc;
        bit bok, to;
        exp_t e;
        sb.push_back(exp_t'{200, 0, ref_cycles(200)});
        start_search(8'd200);
        wait_done(70000, cyc, bok, to);
        e = sb.pop_front();
        n_tests++;
        if (to || uo_out !== 8'h00 || uio_out[3] !== 1'b0 || uio_out[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL not_found got n=%0d found=%b done=%b want n=0 found=0 done=1 timeout=%0b",
                     uo_out, uio_out[3], uio_out[2], to);
        end
        n_tests++;
        if (!bok || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL not_found_sweep got cyc=%0d busy_ok=%0b want cyc=%0d busy_ok=1", cyc, bok, e.cyc);
        end
    endtask

    task automatic test_hold_start();
        int cyc;
        bit bok, to;
        exp_t e;
        sb.push_back(exp_t'{5, 5, 0});
        @(negedge clk);
        ui_in     = 8'd5;
        uio_in[0] = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ui_in = ui_in + 8'd3;
        end
        @(negedge clk);
        uio_in[0] = 1'b0;
        wait_done(70000, cyc, bok, to);
        e = sb.pop_front();
        n_tests++;
        if (to || uo_out !== 8'(e.n)) begin
            n_fail++;
            $display("FAIL hold_start got n=%0d want=%0d timeout=%0b", uo_out, e.n, to);
        end

        sb.push_back(exp_t'{2, 4, ref_cycles(2)});
        start_search(8'd2);
        n_tests++;
        if (uio_out[2] !== 1'b0 || uio_out[3] !== 1'b0 || uio_out[1] !== 1'b1 || uo_out !== 8'h00) begin
            n_fail++;
            $display("FAIL restart_clear got done=%b found=%b busy=%b n=%0d want 0/0/1/0",
                     uio_out[2], uio_out[3], uio_out[1], uo_out);
        end
        wait_done(70000, cyc, bok, to);
        e = sb.pop_front();
        n_tests++;
        if (to || uo_out !== 8'(e.n) || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL restart_result got n=%0d cyc=%0d want n=%0d cyc=%0d timeout=%0b",
                     uo_out, cyc, e.n, e.cyc, to);
        end
    endtask

    task automatic test_sweep();
        int cyc;
        bit bok, to;
        int t;
        exp_t e;
        for (int i = 0; i <= 25; i++) begin
            t = (i == 25) ? 128 : i;
            sb.push_back(exp_t'{t, ref_inverse(t), ref_cycles(t)});
            start_search(8'(t));
            wait_done(70000, cyc, bok, to);
            e = sb.pop_front();
            n_tests++;
            if (to || uo_out !== 8'(e.n) || uio_out[3] !== (e.n != 0) || cyc != e.cyc) begin
                n_fail++;
                $display("FAIL sweep t=%0d got n=%0d found=%b cyc=%0d want n=%0d found=%0b cyc=%0d timeout=%0b",
                         e.t, uo_out, uio_out[3], cyc, e.n, (e.n != 0), e.cyc, to);
            end
            n_tests++;
            if (uio_oe !== 8'h0E || uio_out[0] !== 1'b0 || uio_out[7:4] !== 4'h0) begin
                n_fail++;
                $display("FAIL sweep_pins t=%0d got oe=%h uio_out=%h want oe=0e bit0=0 hi=0", e.t, uio_oe, uio_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_t0_latency();
        test_known();
        test_not_found();
        test_hold_start();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
